// File: rtl/orientation_decoder.sv
// Receive-side orientation decoder: qualifies strobed codes, drives a 3x3 LED grid and signed directions.
// Optional macro ORIENT_FAULT_BLINK_EN makes the fault display blink instead of staying steadily lit.
module orientation_decoder #(
  parameter logic [15:0] STABLE_CYCLES = 16'd1000,
  parameter logic [23:0] BLINK_DIV     = 24'd12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] orientation,
  input  logic       orient_valid,
  output logic [8:0] led_grid,
  output logic [3:0] disp_code,
  output logic [1:0] roll_dir,
  output logic [1:0] pitch_dir,
  output logic       stable,
  output logic       fault,
  output logic       changed
);

  typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cand, w_cand_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [16:0] w_cnt_inc;
  logic        w_commit;
  logic [3:0]  w_commit_code;
  logic [3:0]  w_disp_nxt;
  logic        w_changed_nxt;
  logic [8:0]  w_onehot, w_fault_led, w_led_nxt;
  logic [1:0]  w_roll, w_pitch, w_roll_nxt, w_pitch_nxt;

  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_commit      = 1'b0;
    w_commit_code = r_cand;
    if (orient_valid) begin
      if (orientation > 4'd8) begin
        w_cnt_nxt   = '0;
        w_state_nxt = FAULT;
      end else if (orientation == r_cand && r_cnt != '0) begin
        if (r_cnt != STABLE_CYCLES) w_cnt_nxt = w_cnt_inc[15:0];
        w_commit = (w_cnt_inc == {1'b0, STABLE_CYCLES});
      end else begin
        w_cand_nxt    = orientation;
        w_cnt_nxt     = 16'd1;
        w_commit_code = orientation;
        w_commit      = (STABLE_CYCLES == 16'd1);
      end
      if (w_commit) w_state_nxt = LOCKED;
    end
    w_disp_nxt    = w_commit ? w_commit_code : disp_code;
    w_changed_nxt = w_commit && ((w_commit_code != disp_code) || (r_state != LOCKED));
  end

  // Grid index = row*3+col; roll is +1 toward the right, pitch is +1 toward the top.
  always_comb begin
    w_onehot = '0;
    w_roll   = 2'b00;
    w_pitch  = 2'b00;
    case (w_disp_nxt)
      4'd1:    begin w_onehot[1] = 1'b1;                     w_pitch = 2'b01; end
      4'd2:    begin w_onehot[2] = 1'b1; w_roll = 2'b01;     w_pitch = 2'b01; end
      4'd3:    begin w_onehot[5] = 1'b1; w_roll = 2'b01;                      end
      4'd4:    begin w_onehot[8] = 1'b1; w_roll = 2'b01;     w_pitch = 2'b11; end
      4'd5:    begin w_onehot[7] = 1'b1;                     w_pitch = 2'b11; end
      4'd6:    begin w_onehot[6] = 1'b1; w_roll = 2'b11;     w_pitch = 2'b11; end
      4'd7:    begin w_onehot[3] = 1'b1; w_roll = 2'b11;                      end
      4'd8:    begin w_onehot[0] = 1'b1; w_roll = 2'b11;     w_pitch = 2'b01; end
      default: begin w_onehot[4] = 1'b1;                                      end
    endcase
  end

`ifdef ORIENT_FAULT_BLINK_EN
  logic [23:0] r_blink_cnt, w_blink_cnt_nxt;
  logic        r_blink_on, w_blink_on_nxt;

  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_on_nxt  = r_blink_on;
    if (w_state_nxt == FAULT && r_state != FAULT) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = 1'b1;
    end else if (r_state == FAULT) begin
      if (r_blink_cnt == BLINK_DIV - 24'd1) begin
        w_blink_cnt_nxt = '0;
        w_blink_on_nxt  = ~r_blink_on;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 24'd1;
      end
    end
    w_fault_led = w_blink_on_nxt ? 9'h1FF : 9'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^BLINK_DIV;
  assign w_fault_led    = '1;
`endif

  // Outputs are decoded from next-state values so the registered outputs track the state with no lag.
  always_comb begin
    w_led_nxt   = '0;
    w_roll_nxt  = 2'b00;
    w_pitch_nxt = 2'b00;
    case (w_state_nxt)
      LOCKED: begin
        w_led_nxt   = w_onehot;
        w_roll_nxt  = w_roll;
        w_pitch_nxt = w_pitch;
      end
      FAULT:   w_led_nxt = w_fault_led;
      default: w_led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACQUIRE;
      r_cand    <= '0;
      r_cnt     <= '0;
      led_grid  <= '0;
      disp_code <= '0;
      roll_dir  <= 2'b00;
      pitch_dir <= 2'b00;
      stable    <= 1'b0;
      fault     <= 1'b0;
      changed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      led_grid  <= w_led_nxt;
      disp_code <= w_disp_nxt;
      roll_dir  <= w_roll_nxt;
      pitch_dir <= w_pitch_nxt;
      stable    <= (w_state_nxt == LOCKED);
      fault     <= (w_state_nxt == FAULT);
      changed   <= w_changed_nxt;
    end
  end

endmodule

// File: tb/tb_orientation_decoder.sv
// Directed bench for orientation_decoder with STABLE_CYCLES=4, BLINK_DIV=8.
module tb_orientation_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] orientation = '0;
  logic       orient_valid = 1'b0;
  logic [8:0] led_grid;
  logic [3:0] disp_code;
  logic [1:0] roll_dir, pitch_dir;
  logic       stable, fault, changed;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  orientation_decoder #(
    .STABLE_CYCLES(16'd4),
    .BLINK_DIV(24'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .orientation(orientation),
    .orient_valid(orient_valid),
    .led_grid(led_grid),
    .disp_code(disp_code),
    .roll_dir(roll_dir),
    .pitch_dir(pitch_dir),
    .stable(stable),
    .fault(fault),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [8:0] e_led, input logic [3:0] e_disp,
                         input logic [1:0] e_roll, input logic [1:0] e_pitch,
                         input logic e_stable, input logic e_fault, input logic e_changed);
    chk({tag, ".led"}, led_grid, e_led);
    chk({tag, ".disp"}, {5'd0, disp_code}, {5'd0, e_disp});
    chk({tag, ".roll"}, {7'd0, roll_dir}, {7'd0, e_roll});
    chk({tag, ".pitch"}, {7'd0, pitch_dir}, {7'd0, e_pitch});
    chk({tag, ".stable"}, {8'd0, stable}, {8'd0, e_stable});
    chk({tag, ".fault"}, {8'd0, fault}, {8'd0, e_fault});
    chk({tag, ".changed"}, {8'd0, changed}, {8'd0, e_changed});
  endtask

  task automatic step(input logic v, input logic [3:0] code);
    orient_valid = v;
    orientation  = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 9'h000, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // code 2 qualified after 4 samples
    repeat (3) step(1'b1, 4'd2);
    chk_all("c2_pre", 9'h000, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2);
    chk_all("c2_commit", 9'b000000100, 4'd2, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0);
    chk("c2_pulse_end", {8'd0, changed}, 9'd0);

    // code 3 never qualifies, code 5 does
    repeat (3) step(1'b1, 4'd3);
    chk("c3_hidden", led_grid, 9'b000000100);
    repeat (3) step(1'b1, 4'd5);
    chk("c5_pre", {5'd0, disp_code}, 9'd2);
    step(1'b1, 4'd5);
    chk_all("c5_commit", 9'b010000000, 4'd5, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);

    // re-qualifying the displayed code gives no pulse
    step(1'b1, 4'd3);
    repeat (4) step(1'b1, 4'd5);
    chk_all("c5_requal", 9'b010000000, 4'd5, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);

    // illegal code 12 from LOCKED
    step(1'b1, 4'd12);
    chk_all("f12", 9'h1FF, 4'd5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
`ifdef ORIENT_FAULT_BLINK_EN
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 4'd0);
      chk("blink_lit", led_grid, 9'h1FF);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'd0);
      chk("blink_dark", led_grid, 9'h000);
    end
    step(1'b0, 4'd0);
    chk("blink_relit", led_grid, 9'h1FF);
`else
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd0);
      chk("f12_steady", led_grid, 9'h1FF);
    end
`endif
    repeat (3) step(1'b1, 4'd0);
    chk("f12_hold", {8'd0, fault}, 9'd1);
    step(1'b1, 4'd0);
    chk_all("c0_commit", 9'b000010000, 4'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

    // code 7 strobed every third cycle: samples at edges 1,4,7,10
    for (int i = 1; i <= 9; i++) step((i % 3) == 1, 4'd7);
    chk("c7_pre", led_grid, 9'b000010000);
    step(1'b1, 4'd7);
    chk_all("c7_commit", 9'b000001000, 4'd7, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1);

    // async reset mid-qualification of code 8
    repeat (2) step(1'b1, 4'd8);
    orient_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("rst_mid", 9'h000, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(1'b1, 4'd8);
    chk_all("c8_pre", 9'h000, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd8);
    chk_all("c8_commit", 9'b000000001, 4'd8, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1);

    // illegal code 15 from ACQUIRE
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 4'd15);
    chk_all("f15", 9'h1FF, 4'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
`ifndef ORIENT_FAULT_BLINK_EN
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'd0);
      chk("f15_steady", led_grid, 9'h1FF);
    end
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/orientation_decoder.md
# orientation_decoder

Receive-side counterpart of the orientation encoder: accepts the 4-bit orientation code (0–8) with a sample strobe, qualifies it for a programmable number of consecutive matching samples, and drives a 3x3 attitude LED grid plus reconstructed signed roll/pitch direction bits. It sits between the encoder output and the board LEDs and suppresses flicker near the tilt threshold. It also flags illegal codes (9–15) with a fault display.

## Interface
- STABLE_CYCLES, 16'd1000, number of consecutive identical valid samples required to commit a code (minimum 1).
- BLINK_DIV, 24'd12_500_000, clock cycles per blink half-period in fault display.

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- orientation  input  4  orientation code; 0 Neutral, 1 Up, 2 Up-Right, 3 Right, 4 Down-Right, 5 Down, 6 Down-Left, 7 Left, 8 Up-Left
- orient_valid  input  1  sample strobe; `orientation` is sampled on each rising edge where this is high
- led_grid  output  9  3x3 grid, index = row*3+col, row 0 = top, col 0 = left
- disp_code  output  4  currently committed code
- roll_dir  output  2  signed roll direction of the committed code: 01 = +1, 00 = 0, 11 = −1
- pitch_dir  output  2  signed pitch direction, same encoding
- stable  output  1  high while in LOCKED
- fault  output  1  high while in FAULT
- changed  output  1  one-cycle pulse when disp_code/grid take a new committed value

## Operation
- States: ACQUIRE (post-reset, nothing committed), LOCKED, FAULT.
- Qualifier: candidate register `cand` (4 b), sample counter `cnt` (16 b). Both update only on strobed samples; non-strobed cycles hold both, so gaps do not break a run.
- Valid sample (code ≤ 8):
  - If code == cand and cnt ≠ 0: cnt <= cnt+1, saturating at STABLE_CYCLES; commit when cnt+1 == STABLE_CYCLES.
  - Otherwise: cand <= code, cnt <= 1; commit immediately if STABLE_CYCLES == 1.
- Commit: disp_code <= cand, state <= LOCKED; changed pulses only if disp_code differs or the prior state was not LOCKED. Re-qualifying the displayed code produces no pulse.
- Invalid sample (code 9–15): cnt <= 0; state <= FAULT from any state. Invalid codes are never committed. FAULT is left only through a commit.
- Outputs by state:
  - ACQUIRE: led_grid = 0, dirs = 0.
  - LOCKED: led_grid is one-hot from disp_code (0→bit4, 1→bit1, 2→bit2, 3→bit5, 4→bit8, 5→bit7, 6→bit6, 7→bit3, 8→bit0); dirs decoded from disp_code.
  - FAULT: dirs = 0, stable = 0, fault = 1, disp_code holds the last committed value, and led_grid follows the Configuration section.
- Blink counter: cleared and phase set to lit on FAULT entry. It counts 0..BLINK_DIV−1 and then toggles phase.

## Timing
- Reset values: state ACQUIRE, led_grid 0, disp_code 0, roll_dir 00, pitch_dir 00, stable 0, fault 0, changed 0, cand 0, cnt 0, blink counter 0, blink phase lit.
- All outputs are registered.
- Latency: outputs reflect the new code immediately after the edge that captures the STABLE_CYCLES-th matching sample. With orient_valid held high, that is N edges after the first sample.
- Fault latency: fault = 1 and led_grid = fault pattern immediately after the edge that captures the illegal sample.
- Reset mid-qualification or mid-fault returns every register to its reset value; qualification restarts from cnt = 0.

## Configuration
- ORIENT_FAULT_BLINK_EN defined: in FAULT, led_grid alternates 9'h1FF / 9'h000 every BLINK_DIV cycles, starting lit.
- ORIENT_FAULT_BLINK_EN undefined: in FAULT, led_grid is steady 9'h1FF. The blink counter is not built.

## Test plan
All scenarios use STABLE_CYCLES=4 and BLINK_DIV=8.
- Reset, then orient_valid=1 with code 2 for 4 cycles -> after the 4th edge: led_grid=9'b000000100, roll_dir=01, pitch_dir=01, stable=1, changed high for exactly 1 cycle; before that, led_grid=0.
- Code 3 ×3 samples, then code 5 ×4 -> code 3 is never displayed; after the 4th code-5 sample, led_grid=9'b010000000, disp_code=5, pitch_dir=11, roll_dir=00.
- In LOCKED on code 5, one sample of code 12 -> next edge: fault=1, stable=0, dirs=00, disp_code=5. With the macro, led_grid=1FF for 8 cycles, then 000 for 8 cycles. Then 4 samples of code 0 -> led_grid=9'b000010000, fault=0, changed pulse.
- Code 7 strobed on every third cycle only -> commits after the 4th strobed sample (edge 10 from the first), led_grid=9'b000001000.
- rst asserted after 2 matching samples of code 8, then released -> all outputs at reset values; 4 further samples of code 8 are needed to reach led_grid=9'b000000001.
- Macro undefined, illegal code 15 -> led_grid steady 9'h1FF for 40+ cycles.
